hardware_utf8_seq: RTL
======================

# hardware_utf8_seq

Stream sequencer placed directly upstream of `hardware_utf8`. It accepts a UTF-8 byte stream over a valid/ready handshake and drives the converter's active-low write, read and reset strobes. It emits the transcoded UTF-16 byte stream over a second valid/ready handshake. It handles converter `retry` by draining, clearing and re-writing the held byte, and substitutes U+FFFD for undecodable sequences.

## Interface
- No parameters.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst_in  in  1`: asynchronous active-low reset.
- `s_data  in  8`: UTF-8 input byte.
- `s_valid  in  1`: input byte valid; must stay high with stable `s_data`/`s_last` until accepted.
- `s_last  in  1`: byte is the final byte of the stream; forces a flush of any partial sequence.
- `s_ready  out  1`: byte accepted this cycle.
- `be  in  1`: UTF-16 output is big-endian; passed to the converter as `cbe`.
- `m_data  out  8`: UTF-16 output byte.
- `m_valid  out  1`: output byte valid.
- `m_ready  in  1`: downstream accepts the byte.
- `m_err  out  1`: byte belongs to an erroneous or replacement character.
- `cv_din  out  8`, `cv_cbe  out  1`, `cv_chk_range  out  1` (constant 1).
- `cv_bin  out  1`, `cv_uout  out  1`, `cv_rst_in  out  1`: active-low converter strobes. All other converter strobes are tied high externally.
- `cv_dout  in  8`, `cv_ready  in  1`, `cv_retry  in  1`, `cv_error  in  1`, `cv_uout_eof  in  1`: converter outputs.

## Operation
- FSM states: IDLE, WR, CHK, RD, OUT, REPL0, REPL1, CLR.
- Registers: `retry_pend`, `err_l`.
- IDLE → WR when `s_valid`.
- WR:
  - `cv_bin`=0 and `cv_din`=`s_data` for exactly one cycle.
  - Next state is CHK.
- CHK (converter flags now reflect the written byte):
  - `cv_retry`=1: do not accept the byte; set `retry_pend`=1; go to drain-entry.
  - Otherwise: `s_ready`=1 for this cycle only.
    - If `cv_ready` | `s_last`: go to drain-entry.
    - Else: go to IDLE.
- Drain-entry, evaluated in CHK:
  - `err_l` ← `cv_error` | ~`cv_ready`.
  - If `cv_uout_eof` (no UTF-16 encoding exists): go to REPL0.
  - Else: go to RD.
- RD:
  - `cv_uout`=0 for one cycle.
  - Next state is OUT.
- OUT:
  - `m_valid`=1, `m_data`=`cv_dout`, `m_err`=`err_l`.
  - On `m_ready`: go to CLR if `cv_uout_eof`, else go to RD.
- REPL0/REPL1:
  - Emit U+FFFD with `m_err`=1: FF then FD if `be`, otherwise FD then FF.
  - Each state holds until `m_ready`; REPL1 → CLR.
- CLR:
  - `cv_rst_in`=0 for one cycle.
  - If `retry_pend`: clear it and go to WR (re-write the same held byte).
  - Else: go to IDLE.
- `cv_rst_in` = `rst_in` & (state≠CLR), so the converter is also cleared during block reset.
- Boundary cases:
  - Truncated sequence followed by a non-continuation byte: retry path gives FFFD (err) and then the new byte's character.
  - Lone continuation, overlong, or >U+10FFFF input: ready with no UTF-16 form, so FFFD with err=1.
  - `s_last` on a partial sequence: FFFD, err=1.
  - `s_last` on a complete character: ordinary drain.
  - `s_valid` dropped while in IDLE with a partial sequence: converter state is retained and no output is produced.

## Timing
- Reset values: state=IDLE; `s_ready`=0, `m_valid`=0, `m_data`=0, `m_err`=0; `cv_bin`=1, `cv_uout`=1, `cv_rst_in`=0 while `rst_in` is low; `retry_pend`=0, `err_l`=0.
- Byte write costs 2 cycles (WR, CHK); `s_ready` is a single-cycle pulse in CHK.
- Each output byte costs 2 cycles (RD, OUT) at full `m_ready`. Replacement bytes cost 1 cycle each.
- Character completion to first `m_valid`: 2 cycles (CHK, RD).
- `m_valid`, `m_data` and `m_err` are held stable until `m_ready`.
- Asynchronous reset mid-character discards all pending output. Upstream must hold `rst_in` low for ≥1 clock so the synchronous converter reset takes effect.

## Configuration
- `UTF8SEQ_REPLACE_EN` defined: behaviour as above (REPL0/REPL1 emit U+FFFD).
- Undefined: REPL states are removed. Drain-entry with `cv_uout_eof` goes directly to CLR, and the erroneous character is silently dropped. `m_err` is then asserted only on emitted bytes whose `cv_error` was set.

## Test plan
- LE, input 41 (`s_last`=1) → m: 41 00, err 0; converter cleared afterwards.
- LE, input E2 82 AC → m: AC 20; `s_ready` pulses ×3; err 0.
- LE, input F0 9F 98 80 → m: 3D D8 00 DE; with `be`=1 → D8 3D DE 00.
- LE, input E2 41 → m: FD FF (err 1), then 41 00 (err 0). Byte 41 is written twice and accepted once. Macro off → only 41 00.
- Input C0 80 (overlong) and input 80 (lone continuation) → each yields FD FF with err 1.
- Hold `m_ready` low for 5 cycles mid-surrogate-pair → data stable, no byte lost or duplicated; `rst_in` pulse mid-drain → all outputs at reset values, and the next input 41 yields 41 00.

Source files
------------

// File: rtl/hardware_utf8_seq_if.sv
// Stream-side bundle for hardware_utf8_seq: UTF-8 bytes in, UTF-16 bytes out, plus endianness select.
// The environment uses the master modport and the sequencer uses the slave modport.
interface hardware_utf8_seq_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       be;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_err;

    modport master (
        output s_data, s_valid, s_last, be, m_ready,
        input  s_ready, m_data, m_valid, m_err
    );

    modport slave (
        input  s_data, s_valid, s_last, be, m_ready,
        output s_ready, m_data, m_valid, m_err
    );
endinterface

// File: rtl/hardware_utf8_seq.sv
// Sequencer in front of the hardware_utf8 converter: it writes UTF-8 bytes, drains UTF-16 bytes and clears the converter.
// Define UTF8SEQ_REPLACE_EN to emit U+FFFD for undecodable input; when it is undefined, such input is silently dropped.
module hardware_utf8_seq (
    input  logic                      clk,
    input  logic                      rst_in,
    hardware_utf8_seq_if.slave        strm,
    output logic [7:0]                cv_din,
    output logic                      cv_cbe,
    output logic                      cv_chk_range,
    output logic                      cv_bin,
    output logic                      cv_uout,
    output logic                      cv_rst_in,
    input  logic [7:0]                cv_dout,
    input  logic                      cv_ready,
    input  logic                      cv_retry,
    input  logic                      cv_error,
    input  logic                      cv_uout_eof
);

`ifdef UTF8SEQ_REPLACE_EN
    typedef enum logic [2:0] {IDLE, WR, CHK, RD, OUT, REPL0, REPL1, CLR} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, CHK, RD, OUT, CLR} state_t;
`endif

    state_t state_q, state_d;
    logic   retry_pend_q, retry_pend_d;
    logic   err_l_q, err_l_d;
    logic   drain_entry;

    // A retry, a finished character or end of stream all force the held converter output to be drained.
    assign drain_entry  = cv_retry | cv_ready | strm.s_last;
    assign cv_cbe       = strm.be;
    assign cv_chk_range = 1'b1;
    assign cv_rst_in    = rst_in & (state_q != CLR);

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            retry_pend_q <= 1'b0;
            err_l_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            retry_pend_q <= retry_pend_d;
            err_l_q      <= err_l_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        retry_pend_d  = retry_pend_q;
        err_l_d       = err_l_q;
        strm.s_ready  = 1'b0;
        strm.m_valid  = 1'b0;
        strm.m_data   = 8'h00;
        strm.m_err    = 1'b0;
        cv_bin        = 1'b1;
        cv_uout       = 1'b1;
        cv_din        = 8'h00;

        case (state_q)
            IDLE: begin
                if (strm.s_valid) state_d = WR;
            end
            WR: begin
                cv_bin  = 1'b0;
                cv_din  = strm.s_data;
                state_d = CHK;
            end
            CHK: begin
                // On retry the byte stays unaccepted so upstream keeps presenting it for the re-write.
                if (cv_retry) retry_pend_d = 1'b1;
                else          strm.s_ready = 1'b1;
                if (drain_entry) begin
`ifdef UTF8SEQ_REPLACE_EN
                    err_l_d = cv_error | ~cv_ready;
                    state_d = cv_uout_eof ? REPL0 : RD;
`else
                    err_l_d = cv_error;
                    state_d = cv_uout_eof ? CLR : RD;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                cv_uout = 1'b0;
                state_d = OUT;
            end
            OUT: begin
                strm.m_valid = 1'b1;
                strm.m_data  = cv_dout;
                strm.m_err   = err_l_q;
                if (strm.m_ready) state_d = cv_uout_eof ? CLR : RD;
            end
`ifdef UTF8SEQ_REPLACE_EN
            REPL0: begin
                strm.m_valid = 1'b1;
                strm.m_data  = strm.be ? 8'hFF : 8'hFD;
                strm.m_err   = 1'b1;
                if (strm.m_ready) state_d = REPL1;
            end
            REPL1: begin
                strm.m_valid = 1'b1;
                strm.m_data  = strm.be ? 8'hFD : 8'hFF;
                strm.m_err   = 1'b1;
                if (strm.m_ready) state_d = CLR;
            end
`endif
            CLR: begin
                if (retry_pend_q) begin
                    retry_pend_d = 1'b0;
                    state_d      = WR;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
